// File: rtl/pipe_ctrl.sv
// Pipeline control unit: arbitrates trap/jump redirects and stall requesters,
// drives per-stage stall/flush vectors, and watches for stalls that never clear.
module pipe_ctrl #(
    parameter int                      ADDR_W       = 32,
    parameter int                      STAGES       = 4,
    parameter int                      NUM_REQ      = 4,
    parameter logic [4*NUM_REQ-1:0]    REQ_LEVELS   = {4'd2, 4'd2, 4'd0, 4'd2},
    parameter int                      JUMP_STAGE   = 2,
    parameter int                      FLUSH_CYCLES = 1,
    parameter int                      TIMEOUT      = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                jump_flag_i,
    input  logic [ADDR_W-1:0]   jump_addr_i,
    input  logic                trap_flag_i,
    input  logic [ADDR_W-1:0]   trap_addr_i,
    input  logic [NUM_REQ-1:0]  hold_req_i,
    input  logic                err_clr_i,
    output logic                jump_flag_o,
    output logic [ADDR_W-1:0]   jump_addr_o,
    output logic [STAGES-1:0]   stall_o,
    output logic [STAGES-1:0]   flush_o,
    output logic                timeout_o,
    output logic                hold_err_o,
    output logic                busy_o
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_STALL = 2'd2;

    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
    localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(1);
    localparam logic [WD_W-1:0]  WD_MAX     = WD_W'(TIMEOUT);

    function automatic logic [STAGES-1:0] jump_mask();
        logic [STAGES-1:0] m;
        m = '0;
        for (int s = 1; s < STAGES; s++) begin
            m[s] = (s <= JUMP_STAGE);
        end
        return m;
    endfunction

    localparam logic [STAGES-1:0] JMASK = jump_mask();

    function automatic logic [3:0] max_level(input logic [NUM_REQ-1:0] req);
        logic [3:0] m;
        m = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req[i] && (REQ_LEVELS[4*i +: 4] > m)) begin
                m = REQ_LEVELS[4*i +: 4];
            end
        end
        return m;
    endfunction

    function automatic logic [STAGES-1:0] thermo(input logic [3:0] lvl);
        logic [STAGES-1:0] t;
        for (int s = 0; s < STAGES; s++) begin
            t[s] = (s <= int'(lvl));
        end
        return t;
    endfunction

    function automatic logic [WD_W-1:0] wd_sat_inc(input logic [WD_W-1:0] v);
        return (v == WD_MAX) ? v : v + WD_W'(1);
    endfunction

    logic [1:0]         state_q,    state_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic [WD_W-1:0]    wd_q,       wd_d;
    logic               hold_err_q, hold_err_d;
    logic               busy_q,     busy_d;

    logic               redir;
    logic               any_req;
    logic [STAGES-1:0]  stall_raw;
    logic               stalled;

    always_comb begin
        redir       = trap_flag_i | jump_flag_i;
        jump_flag_o = redir;
        jump_addr_o = trap_flag_i ? trap_addr_i : jump_addr_i;

        any_req   = |hold_req_i;
        stall_raw = any_req ? thermo(max_level(hold_req_i)) : '0;

        // Redirect cycle releases every register so the PC can take the target.
        stall_o = stall_raw;
        flush_o = '0;
        if (redir) begin
            stall_o = '0;
            flush_o = JMASK;
        end else if (state_q == ST_FLUSH) begin
            stall_o = stall_raw & ~JMASK;
            flush_o = JMASK;
        end

        state_d = state_q;
        cnt_d   = cnt_q;
        if (redir) begin
            if (FLUSH_CYCLES == 1) begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end else begin
                state_d = ST_FLUSH;
                cnt_d   = CNT_RELOAD;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (any_req) state_d = ST_STALL;
                end
                ST_FLUSH: begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = any_req ? ST_STALL : ST_RUN;
                    end
                end
                ST_STALL: begin
                    if (!any_req) state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            endcase
        end
        busy_d = (state_d != ST_RUN);

        // Watchdog: pulse only on the cycle the count reaches its ceiling.
        stalled    = |stall_o;
        wd_d       = stalled ? wd_sat_inc(wd_q) : '0;
        timeout_o  = stalled && (wd_q != WD_MAX) && (wd_d == WD_MAX);
        hold_err_d = timeout_o ? 1'b1 : (err_clr_i ? 1'b0 : hold_err_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            cnt_q      <= '0;
            wd_q       <= '0;
            hold_err_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wd_q       <= wd_d;
            hold_err_q <= hold_err_d;
            busy_q     <= busy_d;
        end
    end

    assign hold_err_o = hold_err_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: one instance with a 3-cycle flush window and a
// short watchdog, a second with a 2-cycle window for redirect-during-flush.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic        trap_flag_i;
    logic [31:0] trap_addr_i;
    logic [3:0]  hold_req_i;
    logic        err_clr_i;

    logic        a_jf, b_jf;
    logic [31:0] a_ja, b_ja;
    logic [3:0]  a_stall, b_stall, a_flush, b_flush;
    logic        a_to, b_to, a_err, b_err, a_busy, b_busy;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Levels: req0=2, req1=2, req2=0, req3=2.
    pipe_ctrl #(.ADDR_W(32), .STAGES(4), .NUM_REQ(4), .REQ_LEVELS(16'h2022),
                .JUMP_STAGE(2), .FLUSH_CYCLES(3), .TIMEOUT(4)) u_a (
        .clk(clk), .rst(rst),
        .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
        .trap_flag_i(trap_flag_i), .trap_addr_i(trap_addr_i),
        .hold_req_i(hold_req_i), .err_clr_i(err_clr_i),
        .jump_flag_o(a_jf), .jump_addr_o(a_ja), .stall_o(a_stall), .flush_o(a_flush),
        .timeout_o(a_to), .hold_err_o(a_err), .busy_o(a_busy));

    // Levels: req0=3 so a full-depth stall shows the masked FLUSH pattern.
    pipe_ctrl #(.ADDR_W(32), .STAGES(4), .NUM_REQ(4), .REQ_LEVELS(16'h2023),
                .JUMP_STAGE(2), .FLUSH_CYCLES(2), .TIMEOUT(255)) u_b (
        .clk(clk), .rst(rst),
        .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
        .trap_flag_i(trap_flag_i), .trap_addr_i(trap_addr_i),
        .hold_req_i(hold_req_i), .err_clr_i(err_clr_i),
        .jump_flag_o(b_jf), .jump_addr_o(b_ja), .stall_o(b_stall), .flush_o(b_flush),
        .timeout_o(b_to), .hold_err_o(b_err), .busy_o(b_busy));

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        jump_flag_i = 1'b1; jump_addr_i = 32'h40;
        cyc();
        jump_flag_i = 1'b0;
        #4;
        n_chk++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL rst_pre_busy got %b want 1", a_busy); end
        cyc();
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        #4;
        n_chk++; if (a_stall !== 4'b0000) begin n_fail++; $display("FAIL rst_stall got %b want 0000", a_stall); end
        n_chk++; if (a_flush !== 4'b0000) begin n_fail++; $display("FAIL rst_flush got %b want 0000", a_flush); end
        n_chk++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", a_busy); end
        n_chk++; if (a_err !== 1'b0 || a_to !== 1'b0) begin n_fail++; $display("FAIL rst_wd got err=%b to=%b want 0 0", a_err, a_to); end
        n_chk++; if (a_jf !== 1'b0) begin n_fail++; $display("FAIL rst_jf got %b want 0", a_jf); end
        cyc();
    endtask

    task automatic test_jump();
        jump_flag_i = 1'b1; jump_addr_i = 32'h0000_0100;
        #4;
        n_chk++; if (a_jf !== 1'b1) begin n_fail++; $display("FAIL jmp_flag got %b want 1", a_jf); end
        n_chk++; if (a_ja !== 32'h100) begin n_fail++; $display("FAIL jmp_addr got %h want 00000100", a_ja); end
        n_chk++; if (a_stall !== 4'b0000) begin n_fail++; $display("FAIL jmp_stall got %b want 0000", a_stall); end
        n_chk++; if (a_flush !== 4'b0110) begin n_fail++; $display("FAIL jmp_flush0 got %b want 0110", a_flush); end
        cyc();
        jump_flag_i = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            #4;
            n_chk++; if (a_flush !== ((k < 3) ? 4'b0110 : 4'b0000)) begin n_fail++; $display("FAIL jmp_flush%0d got %b", k, a_flush); end
            n_chk++; if (a_busy !== (k < 3)) begin n_fail++; $display("FAIL jmp_busy%0d got %b want %b", k, a_busy, (k < 3)); end
            cyc();
        end
    endtask

    task automatic test_trap_priority();
        trap_flag_i = 1'b1; trap_addr_i = 32'h8;
        jump_flag_i = 1'b1; jump_addr_i = 32'h100;
        #4;
        n_chk++; if (a_ja !== 32'h8) begin n_fail++; $display("FAIL trap_addr got %h want 00000008", a_ja); end
        n_chk++; if (a_flush !== 4'b0110) begin n_fail++; $display("FAIL trap_flush got %b want 0110", a_flush); end
        cyc();
        jump_flag_i = 1'b0; trap_addr_i = 32'hC;
        #4;
        n_chk++; if (a_ja !== 32'hC || a_jf !== 1'b1) begin n_fail++; $display("FAIL trap_only got %h/%b want 0000000c/1", a_ja, a_jf); end
        cyc();
        trap_flag_i = 1'b0;
        cyc(); cyc();
        jump_addr_i = 32'h123;
        #4;
        n_chk++; if (a_ja !== 32'h123 || a_jf !== 1'b0) begin n_fail++; $display("FAIL noredir got %h/%b want 00000123/0", a_ja, a_jf); end
        n_chk++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL trap_end_busy got %b want 0", a_busy); end
        cyc();
    endtask

    task automatic test_stall();
        hold_req_i = 4'b0100;
        #4;
        n_chk++; if (a_stall !== 4'b0001) begin n_fail++; $display("FAIL stall_l0 got %b want 0001", a_stall); end
        n_chk++; if (a_flush !== 4'b0000) begin n_fail++; $display("FAIL stall_flush got %b want 0000", a_flush); end
        cyc();
        hold_req_i = 4'b0101;
        #4;
        n_chk++; if (a_stall !== 4'b0111) begin n_fail++; $display("FAIL stall_l2 got %b want 0111", a_stall); end
        n_chk++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL stall_busy got %b want 1", a_busy); end
        cyc();
        hold_req_i = 4'b0000;
        #4;
        n_chk++; if (a_stall !== 4'b0000) begin n_fail++; $display("FAIL stall_drop got %b want 0000", a_stall); end
        cyc();
        #4;
        n_chk++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL stall_run got %b want 0", a_busy); end
        cyc();
    endtask

    task automatic test_watchdog();
        hold_req_i = 4'b0001;
        for (int k = 1; k <= 6; k++) begin
            #4;
            n_chk++; if (a_stall !== 4'b0111) begin n_fail++; $display("FAIL wd_stall%0d got %b want 0111", k, a_stall); end
            n_chk++; if (a_to !== (k == 4)) begin n_fail++; $display("FAIL wd_to%0d got %b want %b", k, a_to, (k == 4)); end
            n_chk++; if (a_err !== (k >= 5)) begin n_fail++; $display("FAIL wd_err%0d got %b want %b", k, a_err, (k >= 5)); end
            cyc();
        end
        hold_req_i = 4'b0000;
        #4;
        n_chk++; if (a_err !== 1'b1 || a_to !== 1'b0) begin n_fail++; $display("FAIL wd_sticky got err=%b to=%b want 1 0", a_err, a_to); end
        cyc();
        err_clr_i = 1'b1;
        cyc();
        err_clr_i = 1'b0;
        #4;
        n_chk++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL wd_clr got %b want 0", a_err); end
        cyc();
        hold_req_i = 4'b0001;
        cyc(); cyc(); cyc();
        err_clr_i = 1'b1;
        #4;
        n_chk++; if (a_to !== 1'b1) begin n_fail++; $display("FAIL wd_to_again got %b want 1", a_to); end
        cyc();
        err_clr_i = 1'b0;
        hold_req_i = 4'b0000;
        #4;
        n_chk++; if (a_err !== 1'b1) begin n_fail++; $display("FAIL wd_setwins got %b want 1", a_err); end
        cyc();
        err_clr_i = 1'b1;
        cyc();
        err_clr_i = 1'b0;
        cyc();
    endtask

    task automatic test_back_to_back();
        jump_flag_i = 1'b1; jump_addr_i = 32'h200;
        #4;
        n_chk++; if (b_ja !== 32'h200 || b_flush !== 4'b0110) begin n_fail++; $display("FAIL b2b_first got %h/%b want 00000200/0110", b_ja, b_flush); end
        cyc();
        jump_addr_i = 32'h300; hold_req_i = 4'b0001;
        #4;
        n_chk++; if (b_ja !== 32'h300) begin n_fail++; $display("FAIL b2b_addr got %h want 00000300", b_ja); end
        n_chk++; if (b_stall !== 4'b0000) begin n_fail++; $display("FAIL b2b_stall got %b want 0000", b_stall); end
        n_chk++; if (b_flush !== 4'b0110 || b_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_flush got %b/%b want 0110/1", b_flush, b_busy); end
        cyc();
        jump_flag_i = 1'b0;
        #4;
        n_chk++; if (b_stall !== 4'b1001) begin n_fail++; $display("FAIL b2b_mask got %b want 1001", b_stall); end
        n_chk++; if (b_flush !== 4'b0110) begin n_fail++; $display("FAIL b2b_reload got %b want 0110", b_flush); end
        cyc();
        #4;
        n_chk++; if (b_stall !== 4'b1111 || b_flush !== 4'b0000) begin n_fail++; $display("FAIL b2b_after got %b/%b want 1111/0000", b_stall, b_flush); end
        n_chk++; if (b_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy got %b want 1", b_busy); end
        hold_req_i = 4'b0000;
        cyc(); cyc();
    endtask

    initial begin
        rst = 1'b1;
        jump_flag_i = 1'b0; jump_addr_i = '0;
        trap_flag_i = 1'b0; trap_addr_i = '0;
        hold_req_i  = '0;   err_clr_i   = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        test_reset();
        test_jump();
        test_trap_priority();
        test_stall();
        test_watchdog();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Parametrised pipeline control unit: arbitrates redirect (jump/trap) requests and NUM_REQ stall requesters, and drives per-stage stall and flush vectors for a STAGES-deep in-order pipeline.
- Successor to the fixed two-level hold controller. Adds per-requester stall depth, a multi-cycle post-redirect flush window, trap-over-jump priority and a stall watchdog.
- Sits between ex/clint/rib/mem requesters and the pc_reg and pipeline registers.

Parameters:
ADDR_W, 32, redirect address width
STAGES, 4, pipeline register count; index 0 = PC, 1 = IF/ID, 2 = ID/EX, 3 = EX/MEM
NUM_REQ, 4, number of stall requesters
REQ_LEVELS, {4'd2,4'd2,4'd0,4'd2}, packed 4-bit level per requester (req i = bits 4i+3:4i); level L stalls stages 0..L; L < STAGES
JUMP_STAGE, 2, highest stage flushed on redirect (flush bits 1..JUMP_STAGE)
FLUSH_CYCLES, 1, cycles flush_o stays asserted per redirect, >= 1
TIMEOUT, 255, consecutive stalled cycles before watchdog fires, >= 1

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
jump_flag_i  in  1  ex branch/jump redirect request
jump_addr_i  in  ADDR_W  ex redirect target
trap_flag_i  in  1  clint trap/mret redirect request
trap_addr_i  in  ADDR_W  clint redirect target
hold_req_i  in  NUM_REQ  stall request per requester
err_clr_i  in  1  clears hold_err_o
jump_flag_o  out  1  redirect to pc_reg
jump_addr_o  out  ADDR_W  redirect target to pc_reg
stall_o  out  STAGES  per-stage hold; bit s = register s keeps its value
flush_o  out  STAGES  per-stage bubble insert; bit 0 always 0
timeout_o  out  1  one-cycle watchdog pulse
hold_err_o  out  1  sticky watchdog flag
busy_o  out  1  state != RUN

Behaviour:
- Reset, checked on the clk edge when rst=1: state=RUN, flush counter=0, watchdog counter=0, timeout_o=0, hold_err_o=0. rst has priority over every other input, including reset in the middle of FLUSH or a stall.
- Redirect path is combinational, zero latency:
  - redir = trap_flag_i | jump_flag_i.
  - Trap wins: with both asserted, jump_addr_o = trap_addr_i; otherwise the address of the active source. With no redirect, jump_addr_o = jump_addr_i.
  - jump_flag_o = redir.
- Stall computation (combinational):
  - lvl = maximum REQ_LEVELS[i] over all i with hold_req_i[i]=1.
  - stall_raw = thermometer of bits 0..lvl, or all zero when no request.
- Redirect cycle (redir=1): stall_o = 0 so the PC loads the target; flush_o bits 1..JUMP_STAGE = 1.
- FSM states: RUN, FLUSH, STALL. Transitions evaluated at the clk edge:
  - RUN:
    - redir: FLUSH_CYCLES=1 stays RUN; otherwise cnt <= FLUSH_CYCLES-1 and go to FLUSH.
    - else any hold_req_i: go to STALL.
  - FLUSH:
    - flush_o bits 1..JUMP_STAGE = 1.
    - stall_o = stall_raw with bits 1..JUMP_STAGE masked to 0; bit 0 and bits above JUMP_STAGE pass through.
    - cnt decrements.
    - New redir reloads cnt to FLUSH_CYCLES-1 and takes the new target.
    - cnt==1 and no redir: go to RUN if no request, else STALL.
  - STALL:
    - stall_o = stall_raw, flush_o = 0.
    - redir: handled as in RUN; the redirect cycle has priority.
    - All requests drop: go to RUN.
  - In RUN with no redirect: stall_o = stall_raw, flush_o = 0.
- Watchdog:
  - wd counter width = clog2(TIMEOUT+1).
  - Increments on each cycle with stall_o != 0 and saturates at TIMEOUT.
  - Cleared on any cycle with stall_o == 0 or redir.
  - When it increments to TIMEOUT: timeout_o = 1 for exactly that one registered cycle; hold_err_o <= 1.
  - hold_err_o stays set until err_clr_i or rst. If err_clr_i and a new timeout land in the same cycle, the set wins.
  - timeout_o does not re-pulse while the counter stays saturated.
- busy_o = (state != RUN), registered.
- Requests are level-sensitive and sampled every cycle; no handshake or acknowledge.

Test Plan:
- Reset with rst=1 held for 2 cycles mid-FLUSH, then released -> all outputs 0, state RUN, hold_err_o=0.
- jump_flag_i=1, jump_addr_i=0x0000_0100 for one cycle, FLUSH_CYCLES=3 -> same cycle: jump_flag_o=1, jump_addr_o=0x100, stall_o=0000, flush_o=0110. flush_o=0110 for 2 further cycles, then 0000; busy_o high for 2 cycles.
- trap_flag_i and jump_flag_i together, trap_addr_i=0x8 -> jump_addr_o=0x8, flush_o=0110.
- hold_req_i=0b0100 (level 0), then 0b0101 (levels 0 and 2) -> stall_o=0001, then 0111; requests drop -> 0000 next cycle and state RUN.
- TIMEOUT=4, hold_req_i[0] held for 6 cycles -> timeout_o=1 only on the 4th stalled cycle; hold_err_o=1 from the following cycle and stays 1 after the requests drop; err_clr_i pulse -> 0.
- FLUSH_CYCLES=2, second jump in the first FLUSH cycle plus hold_req_i[0] active -> new target output, flush counter reloaded, stall_o=0000 in the redirect cycle, then stall_o=1001 with bits 1..2 masked.
